branch_resolve_queue: RTL and testbench

In-order queue of in-flight conditional-branch predictions between the fetch-stage gshare predictor and the execute stage. Each predicted branch is pushed at fetch with its PC, predicted direction, predicted target and gshare table index. The oldest entry is resolved against the execute-stage outcome. The block emits the predictor training update (index plus actual direction), and on a misprediction it emits a one-cycle flush with the redirect PC and discards all younger entries.

---
 rtl/brq_pkg.sv | 20 ++
 rtl/brq_fifo.sv | 69 ++++++
 rtl/branch_resolve_queue.sv | 125 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
package brq_pkg;

    localparam int BRQ_XLEN       = 32;
    localparam int BRQ_IDX_W      = 5;
    localparam int BRQ_INSN_BYTES = 4;

    typedef struct packed {
        logic [BRQ_XLEN-1:0]  pc;
        logic                 pred_taken;
        logic [BRQ_XLEN-1:0]  pred_target;
        logic [BRQ_IDX_W-1:0] index;
    } brq_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } brq_state_e;

endpackage

// File: rtl/brq_fifo.sv
// Circular buffer of branch entries with push, pop, whole-queue clear and occupancy count.
module brq_fifo
    import brq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  brq_entry_t               i_push_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output brq_entry_t               o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    brq_entry_t           mem_q [DEPTH];
    brq_entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]       count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Clear wins: the caller never pushes or pops in a clear cycle.
        if (i_clear) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (i_push) begin
                mem_d[tail_q] = i_push_data;
                tail_d        = tail_q + 1'b1;
            end
            if (i_pop) begin
                head_d = head_q + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

    assign o_head  = mem_q[head_q];
    assign o_count = count_q;
    assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of gshare predictions resolved against execute; emits training updates and flushes.
// Optional statistics counters are built when BRQ_STATS_EN is defined.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = BRQ_XLEN,
    parameter int IDX_W = BRQ_IDX_W
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push_valid,
    input  logic [XLEN-1:0]        i_push_pc,
    input  logic                   i_push_pred_taken,
    input  logic [XLEN-1:0]        i_push_pred_target,
    input  logic [IDX_W-1:0]       i_push_index,
    output logic                   o_push_ready,
    input  logic                   i_res_valid,
    input  logic                   i_res_taken,
    input  logic [XLEN-1:0]        i_res_target,
    output logic                   o_res_ready,
    output logic                   o_update_valid,
    output logic [IDX_W-1:0]       o_update_index,
    output logic                   o_update_taken,
    output logic                   o_flush,
    output logic [XLEN-1:0]        o_redirect_pc,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [31:0]            o_stat_branches,
    output logic [31:0]            o_stat_mispred
);

    brq_state_e       state_q, state_d;
    brq_entry_t       head, push_data;
    logic             full, empty, push_fire, res_fire, mispred;
    logic [XLEN-1:0]  correct_pc;
    logic             update_valid_q, update_valid_d, update_taken_q, update_taken_d;
    logic             flush_q, flush_d;
    logic [IDX_W-1:0] update_index_q, update_index_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

    assign push_data = '{pc: i_push_pc, pred_taken: i_push_pred_taken,
                         pred_target: i_push_pred_target, index: i_push_index};

    assign o_push_ready = (state_q == RUN) && !full;
    assign o_res_ready  = (state_q == RUN) && !empty;
    assign push_fire    = i_push_valid && o_push_ready;
    assign res_fire     = i_res_valid && o_res_ready;
    assign mispred      = res_fire && ((i_res_taken != head.pred_taken) ||
                                       (i_res_taken && (i_res_target != head.pred_target)));
    assign correct_pc   = i_res_taken ? i_res_target : head.pc + XLEN'(BRQ_INSN_BYTES);

    // A push alongside a mispredict is on the wrong path and is dropped.
    brq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (push_fire && !mispred),
        .i_push_data (push_data),
        .i_pop       (res_fire && !mispred),
        .i_clear     (mispred),
        .o_head      (head),
        .o_count     (o_count),
        .o_full      (full),
        .o_empty     (empty)
    );

    always_comb begin
        state_d        = RUN;
        update_valid_d = res_fire;
        update_index_d = res_fire ? head.index : '0;
        update_taken_d = res_fire && i_res_taken;
        flush_d        = mispred;
        redirect_pc_d  = mispred ? correct_pc : '0;
        if (state_q == RUN && mispred) state_d = RECOVER;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= RUN;
            update_valid_q <= 1'b0;
            update_index_q <= '0;
            update_taken_q <= 1'b0;
            flush_q        <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            state_q        <= state_d;
            update_valid_q <= update_valid_d;
            update_index_q <= update_index_d;
            update_taken_q <= update_taken_d;
            flush_q        <= flush_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign o_update_valid = update_valid_q;
    assign o_update_index = update_index_q;
    assign o_update_taken = update_taken_q;
    assign o_flush        = flush_q;
    assign o_redirect_pc  = redirect_pc_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d, stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q + {31'd0, res_fire};
        stat_mispred_d  = stat_mispred_q + {31'd0, mispred};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign o_stat_branches = stat_branches_q;
    assign o_stat_mispred  = stat_mispred_q;
`else
    assign o_stat_branches = '0;
    assign o_stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=4, XLEN=32, IDX_W=5).
module tb_branch_resolve_queue;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_push_valid, i_push_pred_taken, i_res_valid, i_res_taken;
    logic [31:0] i_push_pc, i_push_pred_target, i_res_target;
    logic [4:0]  i_push_index;
    logic        o_push_ready, o_res_ready, o_update_valid, o_update_taken, o_flush;
    logic [4:0]  o_update_index;
    logic [31:0] o_redirect_pc, o_stat_branches, o_stat_mispred;
    logic [2:0]  o_count;

    int n_chk = 0;
    int n_pass = 0;

    always #5 i_clk = ~i_clk;

    branch_resolve_queue #(.DEPTH(4), .XLEN(32), .IDX_W(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_push_valid(i_push_valid), .i_push_pc(i_push_pc),
        .i_push_pred_taken(i_push_pred_taken), .i_push_pred_target(i_push_pred_target),
        .i_push_index(i_push_index), .o_push_ready(o_push_ready),
        .i_res_valid(i_res_valid), .i_res_taken(i_res_taken), .i_res_target(i_res_target),
        .o_res_ready(o_res_ready), .o_update_valid(o_update_valid),
        .o_update_index(o_update_index), .o_update_taken(o_update_taken),
        .o_flush(o_flush), .o_redirect_pc(o_redirect_pc), .o_count(o_count),
        .o_stat_branches(o_stat_branches), .o_stat_mispred(o_stat_mispred)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are then read at the same point.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                        input logic [4:0] idx);
        i_push_valid = 1'b1; i_push_pc = pc; i_push_pred_taken = pt;
        i_push_pred_target = tgt; i_push_index = idx;
        step();
        i_push_valid = 1'b0;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        i_res_valid = 1'b1; i_res_taken = tk; i_res_target = tgt;
        step();
        i_res_valid = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int br, input int mp);
`ifdef BRQ_STATS_EN
        chk({tag, "_branches"}, 64'(o_stat_branches), 64'(br));
        chk({tag, "_mispred"},  64'(o_stat_mispred),  64'(mp));
`else
        chk({tag, "_branches"}, 64'(o_stat_branches), 64'd0);
        chk({tag, "_mispred"},  64'(o_stat_mispred),  64'd0);
`endif
    endtask

    initial begin
        i_reset = 1'b1; i_push_valid = 1'b0; i_push_pc = '0; i_push_pred_taken = 1'b0;
        i_push_pred_target = '0; i_push_index = '0;
        i_res_valid = 1'b0; i_res_taken = 1'b0; i_res_target = '0;
        step(); step();
        i_reset = 1'b0;
        chk("rst_push_ready", o_push_ready, 1);
        chk("rst_res_ready", o_res_ready, 0);
        chk("rst_count", o_count, 0);
        chk("rst_update", o_update_valid, 0);
        chk("rst_flush", o_flush, 0);
        chk("rst_redirect", o_redirect_pc, 0);
        check_stats("rst", 0, 0);

        // Three not-taken predictions resolved not-taken.
        push(32'h100, 0, 0, 5'd1);
        push(32'h200, 0, 0, 5'd2);
        push(32'h300, 0, 0, 5'd3);
        chk("t1_count3", o_count, 3);
        chk("t1_res_ready", o_res_ready, 1);
        for (int i = 1; i <= 3; i++) begin
            resolve(0, 0);
            chk($sformatf("t1_upd_v%0d", i), o_update_valid, 1);
            chk($sformatf("t1_upd_idx%0d", i), o_update_index, 64'(i));
            chk($sformatf("t1_upd_tk%0d", i), o_update_taken, 0);
            chk($sformatf("t1_flush%0d", i), o_flush, 0);
        end
        chk("t1_count0", o_count, 0);
        step();
        chk("t1_upd_drop", o_update_valid, 0);

        // Fill and hold off a fifth push.
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 16), 0, 0, 5'(10 + i));
        chk("t2_full_ready", o_push_ready, 0);
        chk("t2_count4", o_count, 4);
        push(32'h999, 0, 0, 5'd31);
        chk("t2_count_held", o_count, 4);
        resolve(0, 0);
        chk("t2_ready_again", o_push_ready, 1);
        chk("t2_count3", o_count, 3);
        chk("t2_upd_idx", o_update_index, 10);
        for (int i = 0; i < 3; i++) resolve(0, 0);
        chk("t2_last_idx", o_update_index, 13);
        chk("t2_count0", o_count, 0);

        // Not-taken prediction resolves taken.
        push(32'h100, 0, 0, 5'd4);
        push(32'h200, 0, 0, 5'd5);
        push(32'h300, 0, 0, 5'd6);
        resolve(1, 32'h400);
        chk("t3_flush", o_flush, 1);
        chk("t3_redirect", o_redirect_pc, 32'h400);
        chk("t3_count", o_count, 0);
        chk("t3_push_ready", o_push_ready, 0);
        chk("t3_res_ready", o_res_ready, 0);
        chk("t3_upd_v", o_update_valid, 1);
        chk("t3_upd_tk", o_update_taken, 1);
        chk("t3_upd_idx", o_update_index, 4);
        step();
        chk("t3_flush_gone", o_flush, 0);
        chk("t3_push_ready2", o_push_ready, 1);

        // Wrong target, then taken prediction resolving not-taken.
        push(32'h480, 1, 32'h500, 5'd7);
        resolve(1, 32'h600);
        chk("t4_flush_a", o_flush, 1);
        chk("t4_redirect_a", o_redirect_pc, 32'h600);
        step();
        push(32'h700, 1, 32'h800, 5'd8);
        resolve(0, 0);
        chk("t4_flush_b", o_flush, 1);
        chk("t4_redirect_b", o_redirect_pc, 32'h704);
        chk("t4_upd_tk", o_update_taken, 0);
        check_stats("t4", 10, 3);
        step();

        // Push in a mispredict cycle is dropped; resolve while empty is ignored.
        push(32'h100, 0, 0, 5'd9);
        i_push_valid = 1'b1; i_push_pc = 32'h200; i_push_pred_taken = 1'b0; i_push_index = 5'd11;
        i_res_valid = 1'b1; i_res_taken = 1'b1; i_res_target = 32'h300;
        step();
        i_push_valid = 1'b0; i_res_valid = 1'b0;
        chk("t5_flush", o_flush, 1);
        chk("t5_count", o_count, 0);
        step();
        chk("t5_count_after", o_count, 0);
        resolve(0, 0);
        chk("t5_empty_upd", o_update_valid, 0);
        chk("t5_empty_flush", o_flush, 0);
        check_stats("t5", 11, 4);

        // Reset mid-stream.
        push(32'h100, 0, 0, 5'd1);
        push(32'h200, 0, 0, 5'd2);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("t6_count", o_count, 0);
        chk("t6_push_ready", o_push_ready, 1);
        chk("t6_res_ready", o_res_ready, 0);
        check_stats("t6", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
